// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into visible LED blinks: ON_T ticks lit, then OFF_T ticks dark.
// Optional pending-event queue is built when LED_PULSE_QUEUE_EN is defined.
module led_pulse_stretcher #(
    parameter int PRE_W = 11,
    parameter int T_W   = 8,
    parameter int ON_T  = 8,
    parameter int OFF_T = 8,
    parameter int Q_W   = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           event_in,
    output logic           led_out,
    output logic           busy,
    output logic [Q_W-1:0] pending
);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    localparam logic [T_W-1:0]   ON_LAST  = T_W'(ON_T - 1);
    localparam logic [T_W-1:0]   OFF_LAST = T_W'(OFF_T - 1);
    localparam logic [T_W-1:0]   T_ONE    = T_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    state_t           state;
    logic [PRE_W-1:0] prescaler;
    logic [T_W-1:0]   tcnt;
    logic             tick;
    logic             gap_end;
    logic             active;
    logic             has_pend;

    assign tick    = &prescaler;
    assign gap_end = (state == GAP) && tick && (tcnt == OFF_LAST);
    assign active  = (state == ON) || (state == GAP);

`ifdef LED_PULSE_QUEUE_EN
    localparam logic [Q_W-1:0] Q_ONE = Q_W'(1);
    localparam logic [Q_W-1:0] Q_MAX = '1;

    logic [Q_W-1:0] pend_cnt;

    assign pending  = pend_cnt;
    assign has_pend = (pend_cnt != '0);

    // An event landing on the GAP end cycle is consumed by the restart, never queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt <= '0;
        end else if (gap_end) begin
            if (has_pend && !event_in)
                pend_cnt <= pend_cnt - Q_ONE;
        end else if (active && event_in && (pend_cnt != Q_MAX)) begin
            pend_cnt <= pend_cnt + Q_ONE;
        end
    end
`else
    assign pending  = '0;
    assign has_pend = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            led_out   <= 1'b0;
            busy      <= 1'b0;
            prescaler <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (event_in) begin
                        state     <= ON;
                        led_out   <= 1'b1;
                        busy      <= 1'b1;
                        prescaler <= '0;
                        tcnt      <= '0;
                    end
                end
                ON: begin
                    prescaler <= prescaler + PRE_ONE;
                    if (tick) begin
                        if (tcnt == ON_LAST) begin
                            state     <= GAP;
                            led_out   <= 1'b0;
                            prescaler <= '0;
                            tcnt      <= '0;
                        end else begin
                            tcnt <= tcnt + T_ONE;
                        end
                    end
                end
                GAP: begin
                    prescaler <= prescaler + PRE_ONE;
                    if (gap_end) begin
                        prescaler <= '0;
                        tcnt      <= '0;
                        // Restart straight into ON so back-to-back blinks have no idle cycle.
                        if (has_pend || event_in) begin
                            state   <= ON;
                            led_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tick) begin
                        tcnt <= tcnt + T_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    led_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Output-side counterpart to the input debouncer: turns single-cycle internal event strobes into human-visible LED blinks of fixed on-time and off-gap. It sits between FPGA status logic (Wi-Fi link events, MCU handshake strobes) and the board LED pins. Each accepted event yields one blink. An optional pending queue keeps bursts of events from collapsing into a single blink.

## Interface
Parameters:
- PRE_W, 11, prescaler width; one tick every 2^PRE_W clk cycles
- T_W, 8, width of the tick counter and of ON_T / OFF_T
- ON_T, 8, LED-on duration in ticks; legal range 1..2^T_W-1
- OFF_T, 8, forced LED-off gap after each blink, in ticks; legal range 1..2^T_W-1
- Q_W, 3, pending-event counter width; only used with LED_PULSE_QUEUE_EN

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- event_in  in  1  event strobe, sampled every posedge; each high cycle is one event
- led_out  out  1  registered LED drive, 1 = lit
- busy  out  1  registered, high while in ON or GAP
- pending  out  Q_W  registered count of queued events not yet started; constant 0 without LED_PULSE_QUEUE_EN

## Operation
- FSM states: IDLE, ON, GAP. Reset values: state=IDLE, led_out=0, busy=0, pending=0, prescaler=0, tick counter=0.
- IDLE: event_in=1 -> ON. Prescaler and tick counter cleared on entry.
- ON: led_out=1. Prescaler free-runs 0..2^PRE_W-1 and wraps; a tick is prescaler all-ones. Tick counter increments on each tick. When tick and tick counter == ON_T-1 -> GAP, counters cleared.
- GAP: led_out=0. Counts the same way against OFF_T-1. At the end:
  - pending>0 or event_in=1 -> ON, counters cleared.
  - otherwise -> IDLE.
- Queue, with LED_PULSE_QUEUE_EN:
  - event_in=1 in ON or GAP increments pending, except in the GAP end cycle.
  - GAP end with pending>0 and event_in=0 -> pending-1.
  - GAP end with pending>0 and event_in=1 -> pending unchanged (net zero).
  - GAP end with pending=0 and event_in=1 -> the event starts the next blink directly; pending stays 0.
  - pending saturates at 2^Q_W-1. Further events are dropped; no wrap-around.
- Arithmetic: all counters unsigned. No value outside its declared width is ever produced.
- Reset mid-blink: led_out drops to 0 asynchronously. Any queued events are discarded.

## Timing
- IDLE event at edge k -> led_out=1 and busy=1 from edge k (registered at k).
- ON lasts exactly ON_T*2^PRE_W cycles; GAP lasts exactly OFF_T*2^PRE_W cycles.
- Back-to-back blinks: the next ON starts on the cycle immediately after the last GAP cycle, with no IDLE cycle in between.
- busy falls on the same edge that GAP->IDLE occurs.
- event_in held high for m cycles counts as m events; no edge detection is done.

## Configuration
- LED_PULSE_QUEUE_EN defined:
  - pending counter built and events during ON/GAP are queued as described above.
- LED_PULSE_QUEUE_EN undefined:
  - no counter; pending is tied to 0.
  - events during ON and GAP are ignored, except an event in the GAP end cycle, which still starts a new blink.

## Test plan
All scenarios use PRE_W=2, ON_T=3, OFF_T=2, Q_W=2, so ON = 12 cycles and GAP = 8 cycles.
- Reset check: assert reset asynchronously mid-ON -> led_out, busy and pending read 0 without waiting for a clk edge. Release reset, run 50 cycles with event_in=0 -> all outputs stay 0.
- Single blink: one-cycle event in IDLE -> led_out=1 for exactly 12 cycles, then 0 for 8 cycles with busy=1, then busy=0.
- Queue burst (macro on): 3 events during the first ON -> pending reaches 3. Result: 4 blinks total, each 12 on / 8 off with no gaps between periods, pending decrementing 3->2->1->0 at each GAP end.
- Saturation (macro on): 6 events during ON -> pending holds at 3; exactly 4 blinks are produced.
- Simultaneous event at GAP end:
  - macro on, pending=1: pending stays 1 and the next ON starts.
  - macro off: the event starts a second blink; events injected during ON produce nothing.
